matmul_engine: RTL and testbench
================================

Name: matmul_engine

Overview:
- Parametrised NxN unsigned matrix-multiply engine for the custom-mode datapath; computes C = A x B.
- Fetches A and B from a single-port RAM with synchronous 1-cycle read latency, over a read-only address/data interface.
- Buffers A and B locally and accumulates with one MAC per cycle.
- Presents all N*N results on a flat output bus, with a busy/done handshake to the controlling FSM.
- Generalises the fixed 2x2, 8-bit custom mode to any N, with selectable saturating or wrapping output.

Parameters:
- DATA_W, 8, element width of A, B and C (unsigned).
- N, 2, matrix dimension (N >= 1).
- ADDR_W, 6, RAM address width; must satisfy B_BASE + N*N - 1 < 2**ADDR_W.
- A_BASE, 0, RAM address of A[0][0]; A is stored row-major.
- B_BASE, N*N, RAM address of B[0][0]; B is stored row-major.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  start request; sampled only in IDLE.
- sat_en  in  1  output mode: 1 = saturate, 0 = wrap; latched at start.
- data_i  in  DATA_W  RAM read data; valid the cycle after addr_o.
- addr_o  out  ADDR_W  RAM read address.
- c_o  out  N*N*DATA_W  result array; C[i][j] at bits (i*N+j)*DATA_W +: DATA_W.
- busy_o  out  1  high in FETCH, DRAIN and CALC.
- done_o  out  1  high while in DONE.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state = IDLE; addr_o, c_o, busy_o, done_o, all counters, the accumulator and both buffers = 0. Reset wins over every other event, including mid-operation; no partial result survives it.
- IDLE: if en = 1 at an edge, latch sat_en, clear c_o, clear the fetch index and go to FETCH.
- FETCH: lasts 2*N*N cycles.
  - addr_o = A_BASE + idx for idx < N*N, else B_BASE + (idx - N*N).
  - The data_i returned for idx-1 is written into the A/B buffer each cycle (first cycle: no write).
  - After idx = 2*N*N - 1, go to DRAIN.
- DRAIN: 1 cycle; captures the last B element; addr_o holds its last value. Then go to CALC with i = j = k = 0.
- CALC: N^3 cycles, loop order i (outer), j, k (inner).
  - Each cycle: acc += A[i][k] * B[k][j].
  - When k = N-1: write C[i][j] from (acc + product), then clear acc.
  - After i = j = k = N-1, go to DONE.
- Width rules:
  - Product is 2*DATA_W bits; acc is ACC_W = 2*DATA_W + clog2(N) bits and never overflows.
  - Saturate mode: C = (sum > 2**DATA_W - 1) ? all-ones : sum.
  - Wrap mode: C = sum[DATA_W-1:0].
- DONE: done_o = 1; c_o is stable. Stay until en = 0, then go to IDLE. No re-trigger while en is held high.
- Latency: done_o rises 2*N*N + 1 + N^3 cycles after the edge that sampled en = 1 (17 cycles for N = 2).
- en dropping during FETCH, DRAIN or CALC is ignored; the operation completes.
- Changes on sat_en after the start edge have no effect.
- c_o holds the last result through DONE and IDLE until the next start clears it.
- addr_o is 0 in IDLE and DONE.

Decomposition:
- Shared package matmul_pkg holds:
  - state enum {IDLE, FETCH, DRAIN, CALC, DONE};
  - a clog2 function;
  - localparams ELEMS = N*N and ACC_W.
- One sub-module, matmul_mac: combinational multiply-add plus sat/wrap reduction to DATA_W. The accumulator register lives in the top.

Test Plan:
- Basic, N=2, sat_en=0: RAM[0..3]={1,2,3,4}, RAM[4..7]={5,6,7,8}, pulse en -> addr_o sequence 0..7; done_o high 17 cycles after the start edge; C = {19,22,43,50}.
- Saturate vs wrap, N=2: A all 200, B all 2 (sums = 800) -> sat_en=1 gives C all 255; sat_en=0 gives C all 32. Toggling sat_en mid-run does not change the result.
- Reset mid-CALC: assert rst for 1 cycle during CALC -> next cycle state IDLE, c_o = 0, busy_o = 0, done_o = 0. A fresh start then yields the correct result.
- Handshake: hold en high through DONE -> done_o stays 1 and no new FETCH starts. Deassert en -> IDLE next edge; reassert -> new run with c_o cleared at start.
- Parametrised N=3, DATA_W=8, ADDR_W=6: A = identity, B = {1..9} -> C = {1..9}; done_o rises 2*9 + 1 + 27 = 46 cycles after start; addr_o covers 0..17.
- Boundary: A all 255, B all 255, N=2, sat_en=0 -> sum 130050 is held exactly in the accumulator; C = 130050 mod 256 = 2 for every element.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul_engine codebase slice.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        CALC  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int DEF_DATA_W = 8;
    localparam int DEF_N      = 2;
    localparam int ELEMS      = DEF_N * DEF_N;
    localparam int ACC_W      = 2 * DEF_DATA_W + clog2(DEF_N);

endpackage

// File: rtl/matmul_mac.sv
// Combinational multiply-add with saturating or wrapping reduction to DATA_W.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 17
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_sat,
    output logic [ACC_W-1:0]  o_sum,
    output logic [DATA_W-1:0] o_c
);

    logic [2*DATA_W-1:0] w_prod;

    assign w_prod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
    assign o_sum  = i_acc + ACC_W'(w_prod);

    // Any set bit above DATA_W means the sum exceeds the output range.
    always_comb begin
        if (i_sat && (|o_sum[ACC_W-1:DATA_W])) begin
            o_c = {DATA_W{1'b1}};
        end else begin
            o_c = o_sum[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/matmul_engine.sv
// NxN unsigned matrix multiply: fetches A and B from RAM, then one MAC per cycle.
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N      = 2,
    parameter int ADDR_W = 6,
    parameter int A_BASE = 0,
    parameter int B_BASE = N * N
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       sat_en,
    input  logic [DATA_W-1:0]          data_i,
    output logic [ADDR_W-1:0]          addr_o,
    output logic [N*N*DATA_W-1:0]      c_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int M_ELEMS = N * N;
    localparam int M_ACC_W = 2 * DATA_W + clog2(N);
    localparam int IDX_W   = (clog2(2 * M_ELEMS) < 1) ? 1 : clog2(2 * M_ELEMS);
    localparam int CNT_W   = clog2(N) + 1;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_i;
    logic [CNT_W-1:0]        r_j;
    logic [CNT_W-1:0]        r_k;
    logic [M_ACC_W-1:0]      r_acc;
    logic                    r_sat;
    logic [ADDR_W-1:0]       r_addr;
    logic [N*N*DATA_W-1:0]   r_c;
    logic                    r_busy;
    logic                    r_done;
    logic [DATA_W-1:0]       r_buf [2*M_ELEMS];

    logic [IDX_W-1:0]        w_next_idx;
    logic [IDX_W-1:0]        w_wr_idx;
    logic [IDX_W-1:0]        w_a_idx;
    logic [IDX_W-1:0]        w_b_idx;
    logic [ADDR_W-1:0]       w_next_addr;
    logic [DATA_W-1:0]       w_a;
    logic [DATA_W-1:0]       w_b;
    logic [M_ACC_W-1:0]      w_sum;
    logic [DATA_W-1:0]       w_c;
    logic                    w_k_last;
    logic                    w_j_last;
    logic                    w_i_last;

    // A occupies buffer slots [0, ELEMS), B occupies [ELEMS, 2*ELEMS).
    assign w_next_idx = r_idx + IDX_W'(1);
    assign w_wr_idx   = r_idx - IDX_W'(1);
    assign w_a_idx    = IDX_W'(int'(r_i) * N + int'(r_k));
    assign w_b_idx    = IDX_W'(M_ELEMS + int'(r_k) * N + int'(r_j));
    assign w_a        = r_buf[w_a_idx];
    assign w_b        = r_buf[w_b_idx];
    assign w_k_last   = (r_k == CNT_W'(N - 1));
    assign w_j_last   = (r_j == CNT_W'(N - 1));
    assign w_i_last   = (r_i == CNT_W'(N - 1));

    // RAM address for the next fetch index.
    always_comb begin
        if (int'(w_next_idx) < M_ELEMS) begin
            w_next_addr = ADDR_W'(A_BASE + int'(w_next_idx));
        end else begin
            w_next_addr = ADDR_W'(B_BASE + int'(w_next_idx) - M_ELEMS);
        end
    end

    matmul_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (M_ACC_W)
    ) u_mac (
        .i_acc  (r_acc),
        .i_a    (w_a),
        .i_b    (w_b),
        .i_sat  (r_sat),
        .o_sum  (w_sum),
        .o_c    (w_c)
    );

    // Control FSM, fetch buffers, accumulator and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
            r_addr  <= '0;
            r_c     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int e = 0; e < 2 * M_ELEMS; e++) begin
                r_buf[e] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_sat   <= sat_en;
                        r_c     <= '0;
                        r_idx   <= '0;
                        r_addr  <= ADDR_W'(A_BASE);
                        r_busy  <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    // data_i carries the word addressed on the previous cycle.
                    if (r_idx != '0) begin
                        r_buf[w_wr_idx] <= data_i;
                    end
                    if (r_idx == IDX_W'(2 * M_ELEMS - 1)) begin
                        r_state <= DRAIN;
                    end else begin
                        r_idx  <= w_next_idx;
                        r_addr <= w_next_addr;
                    end
                end
                DRAIN: begin
                    r_buf[IDX_W'(2 * M_ELEMS - 1)] <= data_i;
                    r_i     <= '0;
                    r_j     <= '0;
                    r_k     <= '0;
                    r_acc   <= '0;
                    r_addr  <= '0;
                    r_state <= CALC;
                end
                CALC: begin
                    if (w_k_last) begin
                        r_c[(int'(r_i) * N + int'(r_j)) * DATA_W +: DATA_W] <= w_c;
                        r_acc <= '0;
                        r_k   <= '0;
                        if (w_j_last) begin
                            r_j <= '0;
                            if (w_i_last) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                r_i <= r_i + CNT_W'(1);
                            end
                        end else begin
                            r_j <= r_j + CNT_W'(1);
                        end
                    end else begin
                        r_acc <= w_sum;
                        r_k   <= r_k + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!en) begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign addr_o = r_addr;
    assign c_o    = r_c;
    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule

// File: tb/tb_matmul_engine.sv
// Directed, table-driven bench for matmul_engine at N=2 plus one N=3 instance.
module tb_matmul_engine;

    typedef logic [3:0][7:0] m2_t;

    typedef struct {
        m2_t  a;
        m2_t  b;
        logic sat;
        logic tog;
        m2_t  c;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en2, sat2, en3, sat3;
    logic [7:0]  rd2, rd3;
    logic [5:0]  addr2, addr3;
    logic [31:0] c2;
    logic [71:0] c3;
    logic        busy2, done2, busy3, done3;
    logic [7:0]  ram2 [64];
    logic [7:0]  ram3 [64];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd2 <= ram2[addr2];
        rd3 <= ram3[addr3];
    end

    matmul_engine #(.DATA_W(8), .N(2), .ADDR_W(6)) u_dut2 (
        .clk(clk), .rst(rst), .en(en2), .sat_en(sat2), .data_i(rd2),
        .addr_o(addr2), .c_o(c2), .busy_o(busy2), .done_o(done2)
    );

    matmul_engine #(.DATA_W(8), .N(3), .ADDR_W(6)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .sat_en(sat3), .data_i(rd3),
        .addr_o(addr3), .c_o(c3), .busy_o(busy3), .done_o(done3)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic m2_t pk(input int e0, input int e1, input int e2, input int e3);
        return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    task automatic load2(input m2_t a, input m2_t b);
        for (int e = 0; e < 4; e++) begin
            ram2[e]     = a[e];
            ram2[4 + e] = b[e];
        end
    endtask

    task automatic wait_done2(input string nm);
        int seen;
        seen = 0;
        for (int cyc = 0; cyc < 60 && seen == 0; cyc++) begin
            @(posedge clk); #1;
            if (done2) seen = 1;
        end
        chk({nm, "_done_seen"}, 128'(seen), 128'(1));
    endtask

    // One complete N=2 run: en dropped early, optional sat_en toggling.
    task automatic run2(input string nm, input vec_t v);
        int   lat;
        logic aok;
        load2(v.a, v.b);
        @(negedge clk);
        en2  = 1'b1;
        sat2 = v.sat;
        @(posedge clk); #1;
        chk({nm, "_busy_start"}, 128'(busy2), 128'(1));
        aok = (addr2 == 6'd0);
        lat = 0;
        for (int cyc = 1; cyc <= 60 && lat == 0; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 2) en2 = 1'b0;
            if (v.tog && cyc >= 3) sat2 = ~sat2;
            if (cyc < 8 && addr2 != 6'(cyc)) aok = 1'b0;
            if (cyc == 8 && addr2 != 6'd7) aok = 1'b0;
            if (done2) lat = cyc;
        end
        chk({nm, "_latency"}, 128'(lat), 128'(17));
        chk({nm, "_addr_seq"}, 128'(aok), 128'(1));
        chk({nm, "_c"}, 128'(c2), 128'(v.c));
        chk({nm, "_busy_done"}, 128'(busy2), 128'(0));
        @(posedge clk); #1;
        chk({nm, "_done_fall"}, 128'(done2), 128'(0));
        chk({nm, "_c_idle"}, 128'(c2), 128'(v.c));
        sat2 = 1'b0;
    endtask

    initial begin
        vec_t        vecs [7];
        string       names [7];
        logic [71:0] exp3;
        int          lat;
        logic        aok;

        for (int e = 0; e < 64; e++) begin
            ram2[e] = 8'd0;
            ram3[e] = 8'd0;
        end
        rst = 1'b1; en2 = 1'b0; sat2 = 1'b0; en3 = 1'b0; sat3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr2", 128'(addr2), 128'(0));
        chk("rst_c2", 128'(c2), 128'(0));
        chk("rst_busy2", 128'(busy2), 128'(0));
        chk("rst_done2", 128'(done2), 128'(0));
        chk("rst_c3", 128'(c3), 128'(0));
        chk("rst_busy3", 128'(busy3), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        vecs[0] = '{pk(1,2,3,4),        pk(5,6,7,8), 1'b0, 1'b0, pk(19,22,43,50)};
        vecs[1] = '{pk(200,200,200,200), pk(2,2,2,2), 1'b1, 1'b0, pk(255,255,255,255)};
        vecs[2] = '{pk(200,200,200,200), pk(2,2,2,2), 1'b0, 1'b0, pk(32,32,32,32)};
        vecs[3] = '{pk(200,200,200,200), pk(2,2,2,2), 1'b1, 1'b1, pk(255,255,255,255)};
        vecs[4] = '{pk(255,255,255,255), pk(255,255,255,255), 1'b0, 1'b1, pk(2,2,2,2)};
        vecs[5] = '{pk(10,20,30,40),    pk(1,2,3,4), 1'b1, 1'b0, pk(70,100,150,220)};
        vecs[6] = '{pk(1,0,0,1),        pk(9,8,7,6), 1'b0, 1'b0, pk(9,8,7,6)};
        names = '{"basic", "sat800", "wrap800", "sat_tog", "wrap255_tog", "sat_nosat", "ident"};
        for (int t = 0; t < 7; t++) begin
            run2(names[t], vecs[t]);
        end

        // Reset in the middle of CALC discards the partial result.
        load2(pk(200,200,200,200), pk(2,2,2,2));
        @(negedge clk);
        en2 = 1'b1; sat2 = 1'b1;
        @(posedge clk);
        repeat (14) @(posedge clk);
        #1;
        chk("midcalc_busy", 128'(busy2), 128'(1));
        chk("midcalc_partial", 128'(c2), 128'(pk(255,255,0,0)));
        @(negedge clk);
        rst = 1'b1; en2 = 1'b0;
        @(posedge clk); #1;
        chk("midrst_c", 128'(c2), 128'(0));
        chk("midrst_busy", 128'(busy2), 128'(0));
        chk("midrst_done", 128'(done2), 128'(0));
        chk("midrst_addr", 128'(addr2), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        run2("after_rst", vecs[0]);

        // Handshake: en held through DONE, then release and restart.
        load2(pk(2,0,0,2), pk(1,2,3,4));
        @(negedge clk);
        en2 = 1'b1; sat2 = 1'b0;
        @(posedge clk);
        wait_done2("hs");
        repeat (5) @(posedge clk);
        #1;
        chk("hs_done_held", 128'(done2), 128'(1));
        chk("hs_no_restart", 128'(busy2), 128'(0));
        chk("hs_addr_done", 128'(addr2), 128'(0));
        chk("hs_c_stable", 128'(c2), 128'(pk(2,4,6,8)));
        @(negedge clk);
        en2 = 1'b0;
        @(posedge clk); #1;
        chk("hs_done_low", 128'(done2), 128'(0));
        chk("hs_c_idle", 128'(c2), 128'(pk(2,4,6,8)));
        @(negedge clk);
        en2 = 1'b1;
        @(posedge clk); #1;
        chk("hs_c_cleared", 128'(c2), 128'(0));
        chk("hs_busy_again", 128'(busy2), 128'(1));
        @(negedge clk);
        en2 = 1'b0;
        wait_done2("hs2");
        chk("hs2_c", 128'(c2), 128'(pk(2,4,6,8)));

        // N=3: identity times {1..9}.
        for (int e = 0; e < 9; e++) begin
            ram3[e]     = (e % 4 == 0) ? 8'd1 : 8'd0;
            ram3[9 + e] = 8'(e + 1);
            exp3[e*8 +: 8] = 8'(e + 1);
        end
        @(negedge clk);
        en3 = 1'b1; sat3 = 1'b0;
        @(posedge clk); #1;
        aok = (addr3 == 6'd0);
        lat = 0;
        for (int cyc = 1; cyc <= 100 && lat == 0; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) en3 = 1'b0;
            if (cyc < 18 && addr3 != 6'(cyc)) aok = 1'b0;
            if (done3) lat = cyc;
        end
        chk("n3_latency", 128'(lat), 128'(46));
        chk("n3_addr_seq", 128'(aok), 128'(1));
        chk("n3_c", 128'(c3), 128'(exp3));
        chk("n3_busy_done", 128'(busy3), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
